// File: rtl/softmax_div.sv
// Final softmax stage: streams DATA_SIZE exponent words from memory, divides each by the latched sum, writes quotients.
// Latency: word k is written RD_DELAY+DIV_DELAY cycles after its read address; done follows the last write by one cycle.
// Backpressure: done is held until downstream_ready is high; start is accepted only while ready (idle).
//
// Ports: clk/rst (sync active-high); softmax_div_start/softmax_div_ready/sum = start handshake;
//        rd_addr/rd_data = exponent memory; wr_addr/wr_data/wr_ena = result memory;
//        downstream_ready/softmax_div_done = completion handshake; argmax_idx (optional).
// Optional feature: define SOFTMAX_ARGMAX_EN to add argmax_idx, the index of the largest exponent word.
// DW must be 32 (fp32). RD_DELAY and DIV_DELAY must both be >= 1.
module softmax_div #(
    parameter int AW        = 12,
    parameter int DW        = 32,
    parameter int DATA_SIZE = 128,
    parameter int RD_DELAY  = 1,
    parameter int DIV_DELAY = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          softmax_div_start,
    output logic          softmax_div_ready,
    input  logic [DW-1:0] sum,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_ena,
    input  logic          downstream_ready,
    output logic          softmax_div_done
`ifdef SOFTMAX_ARGMAX_EN
    ,
    output logic [AW-1:0] argmax_idx
`endif
);
    // Total delay from a read address to the matching write strobe.
    localparam int PD = RD_DELAY + DIV_DELAY;
    localparam int CW = $clog2(PD + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   sum_q, sum_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [PD-1:0]   vld_pipe_q, vld_pipe_d;
    logic [AW-1:0]   addr_pipe_q [PD];
    logic [AW-1:0]   addr_pipe_d [PD];
    logic [DW-1:0]   div_pipe_q [DIV_DELAY];
    logic [DW-1:0]   div_pipe_d [DIV_DELAY];
    logic [DW-1:0]   quot;

    // ---------------- control FSM ----------------
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        rd_addr_d   = rd_addr_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (softmax_div_start) begin
                    state_d   = S_RUN;
                    sum_d     = sum;
                    rd_addr_d = '0;
                end
            end
            S_RUN: begin
                if (rd_addr_q == AW'(DATA_SIZE - 1)) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                // Last read address was issued in the final RUN cycle; its write lands PD cycles later.
                if (drain_cnt_q == CW'(PD - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (downstream_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- valid/address/quotient delay lines ----------------
    always_comb begin
        vld_pipe_d[0]  = (state_q == S_RUN);
        addr_pipe_d[0] = rd_addr_q;
        div_pipe_d[0]  = quot;
        for (int i = 1; i < PD; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            addr_pipe_d[i] = addr_pipe_q[i-1];
        end
        for (int i = 1; i < DIV_DELAY; i++) begin
            div_pipe_d[i] = div_pipe_q[i-1];
        end
    end

    // ---------------- fp32 divide rd_data / sum_q ----------------
    // Computed in one step and retimed through the DIV_DELAY-deep div pipe.
    // Denormal operands are treated as zero; round to nearest even.
    logic          sa, sb, sq;
    logic [7:0]    ea, eb;
    logic [22:0]   fa, fb;
    logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [48:0]   num, den;
    logic [25:0]   quo;
    logic [23:0]   rem;
    logic [22:0]   mant;
    logic          guard, sticky, carry;
    logic [22:0]   frac_r;
    logic signed [9:0] exp_t;

    always_comb begin
        sa = rd_data[31];  ea = rd_data[30:23];  fa = rd_data[22:0];
        sb = sum_q[31];    eb = sum_q[30:23];    fb = sum_q[22:0];
        sq = sa ^ sb;
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        // Quotient of the 1.f mantissas scaled by 2^25: lies in [2^24, 2^26).
        num = {1'b1, fa, 25'd0};
        den = {25'd0, 1'b1, fb};
        quo = 26'(num / den);
        rem = 24'(num % den);
        exp_t = 10'sd127 + $signed({2'b00, ea}) - $signed({2'b00, eb});
        if (quo[25]) begin
            mant   = quo[24:2];
            guard  = quo[1];
            sticky = quo[0] | (rem != 24'd0);
        end else begin
            mant   = quo[23:1];
            guard  = quo[0];
            sticky = (rem != 24'd0);
            exp_t  = exp_t - 10'sd1;
        end
        {carry, frac_r} = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
        if (carry) begin
            exp_t = exp_t + 10'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            quot = 32'h7FC0_0000;
        end else if (a_inf || b_zero) begin
            quot = {sq, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            quot = {sq, 31'd0};
        end else if (exp_t >= 10'sd255) begin
            quot = {sq, 8'hFF, 23'd0};
        end else if (exp_t <= 10'sd0) begin
            quot = {sq, 31'd0};
        end else begin
            quot = {sq, exp_t[7:0], frac_r};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            rd_addr_q   <= '0;
            drain_cnt_q <= '0;
            vld_pipe_q  <= '0;
            addr_pipe_q <= '{default: '0};
            div_pipe_q  <= '{default: '0};
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            rd_addr_q   <= rd_addr_d;
            drain_cnt_q <= drain_cnt_d;
            vld_pipe_q  <= vld_pipe_d;
            addr_pipe_q <= addr_pipe_d;
            div_pipe_q  <= div_pipe_d;
        end
    end

    assign softmax_div_ready = (state_q == S_IDLE);
    assign softmax_div_done  = (state_q == S_DONE);
    assign rd_addr           = rd_addr_q;
    assign wr_ena            = vld_pipe_q[PD-1];
    assign wr_addr           = addr_pipe_q[PD-1];
    assign wr_data           = div_pipe_q[DIV_DELAY-1];

`ifdef SOFTMAX_ARGMAX_EN
    // rd_data belongs to the address that entered the pipe RD_DELAY cycles ago.
    // Strict compare keeps the lower index on ties; raw-bit compare is valid for positive fp32.
    logic [DW-1:0] max_val_q, max_val_d;
    logic [AW-1:0] max_idx_q, max_idx_d;

    always_comb begin
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (state_q == S_IDLE && softmax_div_start) begin
            max_val_d = '0;
            max_idx_d = '0;
        end else if (vld_pipe_q[RD_DELAY-1] && (rd_data > max_val_q)) begin
            max_val_d = rd_data;
            max_idx_d = addr_pipe_q[RD_DELAY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign argmax_idx = max_idx_q;
`endif
endmodule

// File: tb/tb_softmax_div.sv
module tb_softmax_div;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int N  = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          softmax_div_start;
    logic          softmax_div_ready;
    logic [DW-1:0] sum;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ena;
    logic          downstream_ready;
    logic          softmax_div_done;
`ifdef SOFTMAX_ARGMAX_EN
    logic [AW-1:0] argmax_idx;
`endif

    softmax_div dut (
        .clk               (clk),
        .rst               (rst),
        .softmax_div_start (softmax_div_start),
        .softmax_div_ready (softmax_div_ready),
        .sum               (sum),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .wr_ena            (wr_ena),
        .downstream_ready  (downstream_ready),
        .softmax_div_done  (softmax_div_done)
`ifdef SOFTMAX_ARGMAX_EN
        ,
        .argmax_idx        (argmax_idx)
`endif
    );

    always #5 clk = ~clk;

    // Source memory with one cycle read latency.
    logic [31:0] mem [N];
    always @(posedge clk) rd_data <= mem[rd_addr[6:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled on the falling edge.
    int          n_wr = 0;
    logic [AW-1:0] w_addr [2048];
    logic [31:0]   w_data [2048];
    int            w_cyc  [2048];
    always @(negedge clk) begin
        if (wr_ena) begin
            if (n_wr < 2048) begin
                w_addr[n_wr] = wr_addr;
                w_data[n_wr] = wr_data;
                w_cyc[n_wr]  = cyc;
            end
            n_wr = n_wr + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cyc;
    int wr_base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] int_to_fp(input int k);
        int p;
        logic [31:0] m;
        if (k == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 31; i++) if (((k >> i) & 1) != 0) p = i;
        m = 32'(k) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // Waits for ready, presents start for one cycle; returns in cycle 1 after acceptance.
    task automatic accept(input logic [31:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (softmax_div_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        softmax_div_start = 1'b1;
        sum               = s;
        acc_cyc           = cyc;
        wr_base           = n_wr;
        tick();
        softmax_div_start = 1'b0;
    endtask

    task automatic wait_done(output int dc, output bit ok);
        ok = 1'b0;
        dc = -1;
        for (int i = 0; i < 400; i++) begin
            if (softmax_div_done) begin
                ok = 1'b1;
                dc = cyc - acc_cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({softmax_div_ready, softmax_div_done, wr_ena} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_flags: ready/done/wr_ena=%b required 100", {softmax_div_ready, softmax_div_done, wr_ena});
        end
        n_cmp++;
        if ({rd_addr, wr_addr, wr_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_buses: rd_addr=%0d wr_addr=%0d wr_data=%h required 0", rd_addr, wr_addr, wr_data);
        end
`ifdef SOFTMAX_ARGMAX_EN
        n_cmp++;
        if (argmax_idx !== '0) begin
            n_bad++;
            $display("FAIL reset_argmax: got %0d required 0", argmax_idx);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_half();
        bit ok;
        int dc, bad;
        for (int k = 0; k < N; k++) mem[k] = 32'h3F80_0000;
        downstream_ready = 1'b1;
        accept(32'h4000_0000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL half_accept: ready never seen"); end
        n_cmp++;
        if ({softmax_div_ready, rd_addr} !== {1'b0, 12'd0}) begin
            n_bad++;
            $display("FAIL half_cycle1: ready=%b rd_addr=%0d required 0/0", softmax_div_ready, rd_addr);
        end
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (rd_addr !== 12'd10) begin
            n_bad++;
            $display("FAIL half_rd_addr11: got %0d required 10", rd_addr);
        end
        wait_done(dc, ok);
        n_cmp++;
        if (!ok || dc != 144) begin
            n_bad++;
            $display("FAIL half_done_cycle: got %0d required 144", dc);
        end
        n_cmp++;
        if (n_wr - wr_base != N) begin
            n_bad++;
            $display("FAIL half_write_count: got %0d required %0d", n_wr - wr_base, N);
        end
        n_cmp++;
        if (w_cyc[wr_base] - acc_cyc != 16 || w_cyc[wr_base + N - 1] - acc_cyc != 143) begin
            n_bad++;
            $display("FAIL half_write_cycles: first %0d last %0d required 16/143",
                     w_cyc[wr_base] - acc_cyc, w_cyc[wr_base + N - 1] - acc_cyc);
        end
        bad = 0;
        for (int k = 0; k < N; k++) begin
            if (w_addr[wr_base + k] !== 12'(k) || w_data[wr_base + k] !== 32'h3F00_0000) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL half_words: %0d words wrong, required addr k and data 3f000000", bad);
        end
        tick();
        n_cmp++;
        if ({softmax_div_ready, softmax_div_done} !== 2'b10) begin
            n_bad++;
            $display("FAIL half_return_idle: ready/done=%b required 10", {softmax_div_ready, softmax_div_done});
        end
    endtask

    task automatic test_identity();
        bit ok;
        int dc, bad;
        for (int k = 0; k < N; k++) mem[k] = int_to_fp(k);
        accept(32'h3F80_0000, ok);
        wait_done(dc, ok);
        n_cmp++;
        if (!ok || dc != 144) begin
            n_bad++;
            $display("FAIL ident_done: got %0d required 144", dc);
        end
        bad = 0;
        for (int k = 0; k < N; k++) begin
            if (w_addr[wr_base + k] !== 12'(k) || w_data[wr_base + k] !== int_to_fp(k)) bad++;
        end
        n_cmp++;
        if (bad != 0 || n_wr - wr_base != N) begin
            n_bad++;
            $display("FAIL ident_words: %0d wrong of %0d writes, required k/1.0 = k", bad, n_wr - wr_base);
        end
`ifdef SOFTMAX_ARGMAX_EN
        n_cmp++;
        if (argmax_idx !== 12'd127) begin
            n_bad++;
            $display("FAIL ident_argmax: got %0d required 127", argmax_idx);
        end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        int dc, bad, base;
        for (int k = 0; k < N; k++) mem[k] = 32'h3F80_0000;
        downstream_ready = 1'b0;
        accept(32'h4000_0000, ok);
        wait_done(dc, ok);
        n_cmp++;
        if (!ok || dc != 144) begin
            n_bad++;
            $display("FAIL bp_done: got %0d required 144", dc);
        end
        bad = 0;
        base = n_wr;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (softmax_div_done !== 1'b1 || softmax_div_ready !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0 || n_wr != base) begin
            n_bad++;
            $display("FAIL bp_hold: %0d bad cycles, %0d extra writes, required 0/0", bad, n_wr - base);
        end
        // start and downstream_ready together while done: start must not be taken.
        softmax_div_start = 1'b1;
        sum               = 32'h3F80_0000;
        downstream_ready  = 1'b1;
        tick();
        softmax_div_start = 1'b0;
        n_cmp++;
        if ({softmax_div_ready, softmax_div_done} !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_release: ready/done=%b required 10", {softmax_div_ready, softmax_div_done});
        end
        tick();
        tick();
        n_cmp++;
        if (softmax_div_ready !== 1'b1 || rd_addr !== 12'd127) begin
            n_bad++;
            $display("FAIL bp_start_in_done: ready=%b rd_addr=%0d required 1/127", softmax_div_ready, rd_addr);
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        int dc, bad;
        for (int k = 0; k < N; k++) mem[k] = 32'h3F80_0000;
        accept(32'h4000_0000, ok);
        for (int i = 0; i < 4; i++) tick();
        softmax_div_start = 1'b1;
        sum               = 32'h3F80_0000;
        tick();
        softmax_div_start = 1'b0;
        for (int i = 0; i < 44; i++) tick();
        softmax_div_start = 1'b1;
        tick();
        softmax_div_start = 1'b0;
        wait_done(dc, ok);
        n_cmp++;
        if (!ok || dc != 144) begin
            n_bad++;
            $display("FAIL ign_done: got %0d required 144", dc);
        end
        bad = 0;
        for (int k = 0; k < N; k++) begin
            if (w_addr[wr_base + k] !== 12'(k) || w_data[wr_base + k] !== 32'h3F00_0000) bad++;
        end
        n_cmp++;
        if (bad != 0 || n_wr - wr_base != N) begin
            n_bad++;
            $display("FAIL ign_words: %0d wrong of %0d writes, required 128 x 3f000000", bad, n_wr - wr_base);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int dc, bad, base;
        for (int k = 0; k < N; k++) mem[k] = 32'h3F80_0000;
        accept(32'h4000_0000, ok);
        for (int i = 0; i < 59; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({softmax_div_ready, wr_ena} !== 2'b10 || n_wr - wr_base != 45) begin
            n_bad++;
            $display("FAIL rstmid_cycle61: ready/wr_ena=%b writes=%0d required 10 and 45",
                     {softmax_div_ready, wr_ena}, n_wr - wr_base);
        end
        base = n_wr;
        for (int i = 0; i < 30; i++) tick();
        n_cmp++;
        if (n_wr != base || softmax_div_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_flushed: %0d stray writes done=%b required 0/0", n_wr - base, softmax_div_done);
        end
        for (int k = 0; k < N; k++) mem[k] = int_to_fp(k);
        accept(32'h4000_0000, ok);
        wait_done(dc, ok);
        bad = 0;
        for (int k = 0; k < N; k++) begin
            if (w_addr[wr_base + k] !== 12'(k) ||
                w_data[wr_base + k] !== (k == 0 ? 32'd0 : int_to_fp(k) - 32'h0080_0000)) bad++;
        end
        n_cmp++;
        if (!ok || dc != 144 || bad != 0 || n_wr - wr_base != N) begin
            n_bad++;
            $display("FAIL rstmid_clean: done=%0d bad=%0d writes=%0d required 144/0/128", dc, bad, n_wr - wr_base);
        end
        tick();
    endtask

`ifdef SOFTMAX_ARGMAX_EN
    task automatic test_argmax_tie();
        bit ok;
        int dc;
        for (int k = 0; k < N; k++) mem[k] = 32'h3F80_0000;
        mem[3]  = 32'h4040_0000;
        mem[90] = 32'h4040_0000;
        accept(32'h3F80_0000, ok);
        wait_done(dc, ok);
        n_cmp++;
        if (!ok || argmax_idx !== 12'd3) begin
            n_bad++;
            $display("FAIL argmax_tie: got %0d required 3", argmax_idx);
        end
        tick();
    endtask
`endif

    initial begin
        rst               = 1'b1;
        softmax_div_start = 1'b0;
        sum               = '0;
        downstream_ready  = 1'b1;
        for (int k = 0; k < N; k++) mem[k] = '0;
        test_reset();
        test_half();
        test_identity();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
`ifdef SOFTMAX_ARGMAX_EN
        test_argmax_tie();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
